// File: rtl/mem_kernel_bank.sv
// mem_kernel_bank
//   Run-time writable store of NUM_KERNELS square KDIM x KDIM signed kernels.
//   It streams one selected kernel to the MAC stage over valid/ready and
//   provides a registered, byte-addressed random-read port for the CPU side.
//
// Ports
//   CLK, RESET                  clock, synchronous active-high reset
//   WE/WSEL/WIDX/WDATA, WERR    coefficient write; WERR pulses one cycle on a
//                               rejected write
//   START/KSEL, BUSY            launch a stream of kernel KSEL; BUSY while streaming
//   OUT_DATA/OUT_IDX/OUT_VALID/
//   OUT_READY/OUT_LAST          coefficient stream, one word per handshake
//   ADDRESS, READ               byte address (word = ADDRESS>>2), 1-cycle read
//
// Build option
//   KERNEL_SUM_EN  adds KSUM / KSUM_VALID: the signed sum of the streamed
//                  kernel, valid the cycle after the final handshake.
module mem_kernel_bank #(
  parameter int SIZE        = 16,
  parameter int KDIM        = 3,
  parameter int NUM_KERNELS = 4,
  parameter int ADDR_W      = 16,
  localparam int N    = KDIM * KDIM,
  localparam int KSW  = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int IW   = (N > 1) ? $clog2(N) : 1,
  localparam int SUMW = SIZE + $clog2(N) + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [KSW-1:0]    WSEL,
  input  logic [IW-1:0]     WIDX,
  input  logic [SIZE-1:0]   WDATA,
  output logic              WERR,
  input  logic              START,
  input  logic [KSW-1:0]    KSEL,
  output logic              BUSY,
  output logic [SIZE-1:0]   OUT_DATA,
  output logic [IW-1:0]     OUT_IDX,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  input  logic [ADDR_W-1:0] ADDRESS,
  output logic [SIZE-1:0]   READ
`ifdef KERNEL_SUM_EN
  ,
  output logic signed [SUMW-1:0] KSUM,
  output logic                   KSUM_VALID
`endif
);

  localparam int WORDS = NUM_KERNELS * N;
  localparam int LW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [WORDS-1:0][SIZE-1:0]  mem;
  logic [KSW-1:0]              ksel_q;
  logic                        hs, start_ok, wr_ok;
  logic [LW-1:0]               wr_addr, st_addr;
  logic [KSW-1:0]              ld_sel;
  logic [IW-1:0]               nxt_idx;
  logic [ADDR_W-3:0]           rd_word;
  logic                        unused_addr_bits;

  assign hs       = (state_q == STREAM) && OUT_READY;
  assign start_ok = (state_q == IDLE) && START;

  // The active kernel is write-protected so a stream always sees one
  // consistent snapshot. Out-of-range kernel selects (non power-of-two
  // NUM_KERNELS) are rejected the same way as out-of-range indices.
  assign wr_ok   = WE && (int'(WIDX) < N) && (int'(WSEL) < NUM_KERNELS) &&
                   !((state_q == STREAM) && (WSEL == ksel_q));
  assign wr_addr = LW'(WSEL) * LW'(N) + LW'(WIDX);

  // ---------------- storage ----------------
  always_ff @(posedge CLK) begin
    if (RESET)      mem <= '0;
    else if (wr_ok) mem[wr_addr] <= WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) WERR <= 1'b0;
    else       WERR <= WE && !wr_ok;
  end

  // ---------------- random read ----------------
  // Registered read of pre-edge storage, so a same-cycle write to the same
  // word returns the old value.
  assign rd_word          = ADDRESS[ADDR_W-1:2];
  assign unused_addr_bits = ^ADDRESS[1:0];

  always_ff @(posedge CLK) begin
    if (RESET)                         READ <= '0;
    else if (int'(rd_word) < WORDS)    READ <= mem[LW'(rd_word)];
    else                               READ <= '0;
  end

  // ---------------- stream FSM ----------------
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = STREAM;
      STREAM:  if (OUT_READY && OUT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state_q == STREAM);
    OUT_VALID = (state_q == STREAM);
  end

  // Word to load into the output register: index 0 of KSEL on launch,
  // otherwise the next index of the latched kernel.
  always_comb begin
    ld_sel  = ksel_q;
    nxt_idx = OUT_IDX + 1'b1;
    if (state_q == IDLE) begin
      ld_sel  = KSEL;
      nxt_idx = '0;
    end
    st_addr = LW'(ld_sel) * LW'(N) + LW'(nxt_idx);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ksel_q   <= '0;
      OUT_DATA <= '0;
      OUT_IDX  <= '0;
      OUT_LAST <= 1'b0;
    end else if (start_ok) begin
      ksel_q   <= KSEL;
      OUT_DATA <= mem[st_addr];
      OUT_IDX  <= '0;
      OUT_LAST <= (N == 1);
    end else if (hs) begin
      if (OUT_LAST) begin
        OUT_LAST <= 1'b0;
      end else begin
        OUT_DATA <= mem[st_addr];
        OUT_IDX  <= nxt_idx;
        OUT_LAST <= (int'(nxt_idx) == N - 1);
      end
    end
  end

`ifdef KERNEL_SUM_EN
  // KSUM doubles as the accumulator: it clears on launch, integrates each
  // accepted word, and is left holding the total once the stream ends.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      KSUM       <= '0;
      KSUM_VALID <= 1'b0;
    end else begin
      KSUM_VALID <= hs && OUT_LAST;
      if (start_ok) KSUM <= '0;
      else if (hs)  KSUM <= KSUM + SUMW'($signed(OUT_DATA));
    end
  end
`endif

endmodule
